plab5_mcore_net_msg_to_mem_resp_adapter: RTL
============================================

// Module: plab5_mcore_net_msg_to_mem_resp_adapter
// PURPOSE
//  Core-side receive adapter for the memory-response network. Accepts network
//  messages whose payload is a memory response, checks the routing header and
//  strips it. Restores the opaque field by clearing the core-id bits that the
//  request path placed in its top ns bits. Buffers responses in a 2-entry queue
//  and presents them to the core's cache/memory port with val/rdy handshaking.
// PARAMETERS
//  p_port_id           0   this core's network index; expected dest of every msg
//  p_mem_opaque_nbits  8   mo: mem response opaque width
//  p_mem_data_nbits    32  md: mem response data width
//  p_net_opaque_nbits  4   no: net header opaque width (ignored on receive)
//  p_net_srcdest_nbits 3   ns: net src/dest width; must satisfy ns < mo
//  p_cnt_nbits         16  width of the delivered/dropped counters
// PORTS
//  clk          in   1                        clock; all state on posedge
//  reset_n      in   1                        async active-low reset
//  net_val      in   1                        input net msg valid
//  net_rdy      out  1                        adapter can accept a net msg
//  net_msg      in   VC_NET_MSG_NBITS(np,no,ns)  np = VC_MEM_RESP_MSG_NBITS(mo,md)
//  memresp_val  out  1                        output mem response valid
//  memresp_rdy  in   1                        core accepts the mem response
//  memresp_msg  out  VC_MEM_RESP_MSG_NBITS(mo,md)  response with restored opaque
//  memresp_src  out  ns                       bank index (net src) of head entry
//  err_misroute out  1                        sticky: a msg with dest!=p_port_id arrived
//  resp_count   out  p_cnt_nbits              responses delivered (wraps)
//  drop_count   out  p_cnt_nbits              misrouted msgs dropped (saturates)
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low.
//  While reset_n=0 the queue is empty: memresp_val=0, net_rdy=0, err_misroute=0,
//  and both counters are 0. net_rdy rises in the first cycle after release.
//  Reset mid-operation flushes queued entries; they are never delivered.
//  Input handshake: a transfer occurs when net_val&&net_rdy at posedge.
//   net_rdy = !full. It is registered-state only, with no combinational path
//   from memresp_rdy. When full, a same-cycle dequeue frees a slot next cycle.
//  Decode on accepted msg: dest = net_msg[VC_NET_MSG_DEST_FIELD], src = SRC field,
//   payload = PAYLOAD field. Net opaque is ignored.
//  dest==p_port_id: enqueue {src, payload'}. payload' equals payload except its
//   opaque field, which becomes {ns'b0, opaque[mo-ns-1:0]}. Type, len and data
//   pass unchanged.
//  dest!=p_port_id: msg is consumed but not enqueued. err_misroute<=1 (sticky
//   until reset). drop_count increments, saturating at all-ones.
//  Output: memresp_val = !empty. memresp_msg and memresp_src come from the head
//   entry and are stable while val&&!rdy. Dequeue occurs on memresp_val&&memresp_rdy.
//  resp_count increments on each dequeue and wraps modulo 2^p_cnt_nbits.
//  Latency: minimum 1 cycle from accept to memresp_val; no bypass path.
//   Throughput is 1 msg/cycle when memresp_rdy is held high.
//  Queue: 2 entries, circular; 1-bit head/tail pointers plus a count of 0..2.
//   Enqueue and dequeue in the same cycle keep the count unchanged; a
//   non-empty queue stays non-empty. Order is strictly FIFO.
//  A misrouted msg accepted while a dequeue occurs changes only the dequeue state.
// STRUCTURE
//  Shared package/header: reuse the VC_NET_MSG_* and VC_MEM_RESP_MSG_* field
//   macros. Add the constant c_net_msg_nbits and a macro for the
//   opaque-restore slice.
//  Unpack with vc_NetMsgUnpack; repack with vc_MemRespMsgPack.
//  One sub-module: plab5_mcore_resp_queue2. This is the 2-entry val/rdy FIFO,
//   parameterised by entry width (ns+np), with async active-low reset.
//  The top level holds decode, route check, opaque restore, err flag and counters.
// TESTING
//  T1 basic: p_port_id=1; msg dest=1, src=2, opaque=8'hA5, data=32'hDEADBEEF,
//   memresp_rdy=1 -> one cycle later memresp_val=1, opaque=8'h05, data=32'hDEADBEEF,
//   memresp_src=2; resp_count=1.
//  T2 backpressure: memresp_rdy=0, send 3 back-to-back msgs -> 2 accepted, then
//   net_rdy=0. With memresp_rdy=1 all 3 are delivered in order with payload intact.
//  T3 streaming: 8 msgs with net_val=1 and memresp_rdy=1 continuously ->
//   1 msg/cycle after the first; resp_count=8.
//  T4 misroute: dest=3 while p_port_id=1 -> net_rdy=1, memresp_val stays 0,
//   err_misroute=1, drop_count=1. A following good msg is delivered normally.
//  T5 reset mid-op: 2 msgs queued, memresp_rdy=0, pulse reset_n=0 asynchronously
//   mid-cycle -> memresp_val=0 immediately; counters and err flag read 0.
//   The queue stays empty after release.
//  T6 counter limits: p_cnt_nbits=2; 5 deliveries -> resp_count=1;
//   5 misroutes -> drop_count=3.

Source files
------------

// File: rtl/plab5_mcore_net_msg_to_mem_resp_adapter_pkg.sv
// Shared message-format helpers for the memory-response network adapter.
// Net message layout, MSB to LSB:      {dest, src, net_opaque, payload}
// Mem response layout, MSB to LSB:     {type, opaque, len, data}
package plab5_mcore_net_msg_to_mem_resp_adapter_pkg;

    localparam int unsigned c_mem_type_nbits = 3;

    typedef enum logic [c_mem_type_nbits-1:0] {
        MEM_TYPE_READ  = 3'd0,
        MEM_TYPE_WRITE = 3'd1,
        MEM_TYPE_INIT  = 3'd2
    } mem_type_e;

    // Byte-length field width for a given data width (at least one bit)
    function automatic int unsigned mem_len_nbits(input int unsigned md);
        int unsigned n;
        n = $clog2(md / 8);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int unsigned mem_resp_msg_nbits(input int unsigned mo,
                                                       input int unsigned md);
        return c_mem_type_nbits + mo + mem_len_nbits(md) + md;
    endfunction

    // LSB of the opaque field inside a mem response
    function automatic int unsigned mem_resp_opaque_lsb(input int unsigned md);
        return md + mem_len_nbits(md);
    endfunction

    function automatic int unsigned net_msg_nbits(input int unsigned np,
                                                  input int unsigned no,
                                                  input int unsigned ns);
        return np + no + 2 * ns;
    endfunction

    // LSB of the src field inside a net message
    function automatic int unsigned net_msg_src_lsb(input int unsigned np,
                                                    input int unsigned no);
        return np + no;
    endfunction

endpackage

// File: rtl/plab5_mcore_resp_queue2.sv
// Two-entry circular val/rdy FIFO with 1-bit head/tail pointers and a 0..2 count.
// enq_rdy depends only on registered state; it stays low until the first
// clock edge after reset is released.
module plab5_mcore_resp_queue2 #(
    parameter int unsigned p_nbits = 8
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);

    logic [p_nbits-1:0] entry0;
    logic [p_nbits-1:0] entry1;
    logic               head;
    logic               tail;
    logic [1:0]         count;
    logic               alive;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy  = alive && (count != 2'd2);
    assign deq_val  = (count != 2'd0);
    assign deq_msg  = head ? entry1 : entry0;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    // Pointer, occupancy and post-reset ready-enable state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive <= 1'b0;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            alive <= 1'b1;
            if (enq_fire) tail <= ~tail;
            if (deq_fire) head <= ~head;
            if (enq_fire && !deq_fire)
                count <= count + 2'd1;
            else if (!enq_fire && deq_fire)
                count <= count - 2'd1;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            if (tail)
                entry1 <= enq_msg;
            else
                entry0 <= enq_msg;
        end
    end

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_resp_adapter.sv
// Core-side receive adapter: checks the routing header of incoming memory
// response network messages, drops misrouted ones, clears the core-id bits
// from the opaque field and queues responses for the core's memory port.
module plab5_mcore_net_msg_to_mem_resp_adapter
    import plab5_mcore_net_msg_to_mem_resp_adapter_pkg::*;
#(
    parameter  int unsigned p_port_id           = 0,
    parameter  int unsigned p_mem_opaque_nbits  = 8,
    parameter  int unsigned p_mem_data_nbits    = 32,
    parameter  int unsigned p_net_opaque_nbits  = 4,
    parameter  int unsigned p_net_srcdest_nbits = 3,
    parameter  int unsigned p_cnt_nbits         = 16,
    localparam int unsigned c_mem_resp_msg_nbits =
        mem_resp_msg_nbits(p_mem_opaque_nbits, p_mem_data_nbits),
    localparam int unsigned c_net_msg_nbits =
        net_msg_nbits(c_mem_resp_msg_nbits, p_net_opaque_nbits, p_net_srcdest_nbits)
)(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             net_val,
    output logic                             net_rdy,
    input  logic [c_net_msg_nbits-1:0]       net_msg,
    output logic                             memresp_val,
    input  logic                             memresp_rdy,
    output logic [c_mem_resp_msg_nbits-1:0]  memresp_msg,
    output logic [p_net_srcdest_nbits-1:0]   memresp_src,
    output logic                             err_misroute,
    output logic [p_cnt_nbits-1:0]           resp_count,
    output logic [p_cnt_nbits-1:0]           drop_count
);

    localparam int unsigned c_ns      = p_net_srcdest_nbits;
    localparam int unsigned c_no      = p_net_opaque_nbits;
    localparam int unsigned c_np      = c_mem_resp_msg_nbits;
    localparam int unsigned c_mo      = p_mem_opaque_nbits;
    localparam int unsigned c_md      = p_mem_data_nbits;
    localparam int unsigned c_ln      = mem_len_nbits(p_mem_data_nbits);
    localparam int unsigned c_opq_lsb = mem_resp_opaque_lsb(p_mem_data_nbits);
    localparam int unsigned c_src_lsb = net_msg_src_lsb(c_np, c_no);
    localparam int unsigned c_q_nbits = c_ns + c_np;

    localparam logic [c_ns-1:0] c_port_id = c_ns'(p_port_id);
    // Keeps the low mo-ns opaque bits; the top ns bits carried the core id
    localparam logic [c_mo-1:0] c_opaque_keep_mask = {{c_ns{1'b0}}, {(c_mo-c_ns){1'b1}}};

    // Unpacked net message
    logic [c_ns-1:0]             dest;
    logic [c_ns-1:0]             src;
    logic [c_no-1:0]             net_opaque;
    logic [c_np-1:0]             payload;

    // Unpacked mem response
    logic [c_mem_type_nbits-1:0] resp_type;
    logic [c_mo-1:0]             resp_opaque;
    logic [c_ln-1:0]             resp_len;
    logic [c_md-1:0]             resp_data;
    logic [c_np-1:0]             payload_restored;

    logic                        dest_ok;
    logic                        q_enq_val;
    logic                        q_enq_rdy;
    logic [c_q_nbits-1:0]        q_enq_msg;
    logic [c_q_nbits-1:0]        q_deq_msg;
    logic                        misroute_fire;
    logic                        deq_fire;

    assign {dest, src, net_opaque, payload} = net_msg;
    assign {resp_type, resp_opaque, resp_len, resp_data} = payload;

    // Repack the response with the core-id bits of the opaque field cleared
    always_comb begin
        payload_restored = {resp_type, resp_opaque & c_opaque_keep_mask, resp_len, resp_data};
    end

    assign dest_ok       = (dest == c_port_id);
    assign q_enq_val     = net_val && dest_ok;
    assign q_enq_msg     = {src, payload_restored};
    assign net_rdy       = q_enq_rdy;
    assign misroute_fire = net_val && net_rdy && !dest_ok;
    assign deq_fire      = memresp_val && memresp_rdy;

    plab5_mcore_resp_queue2 #(
        .p_nbits (c_q_nbits)
    ) resp_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_val (q_enq_val),
        .enq_rdy (q_enq_rdy),
        .enq_msg (q_enq_msg),
        .deq_val (memresp_val),
        .deq_rdy (memresp_rdy),
        .deq_msg (q_deq_msg)
    );

    assign memresp_src = q_deq_msg[c_q_nbits-1:c_np];
    assign memresp_msg = q_deq_msg[c_np-1:0];

    // Sticky misroute flag, saturating drop counter, wrapping delivery counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_misroute <= 1'b0;
            drop_count   <= '0;
            resp_count   <= '0;
        end else begin
            if (misroute_fire) begin
                err_misroute <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + 1'b1;
            end
            if (deq_fire)
                resp_count <= resp_count + 1'b1;
        end
    end

    // net_opaque is deliberately ignored on receive; c_src_lsb documents layout
    logic unused_ok;
    assign unused_ok = ^{net_opaque, c_src_lsb[0]};

endmodule
